// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the stopwatch/timer digit chain.
package stopwatch_pkg;

   typedef logic [3:0] digit_t;

   // Radix nibbles, digit 0 in the LSBs: 10, 10, 6, 10 (seconds/tens/minutes style).
   localparam logic [31:0] DEFAULT_RADIX = 32'h0000_A6AA;

   // Extract the 4-bit radix of digit i from the packed radix word.
   function automatic digit_t radix_of(input logic [31:0] radix, input int i);
      return radix[i*4 +: 4];
   endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit with programmable radix; steps up or down and exports carry/borrow.
module bcd_digit_cell
   import stopwatch_pkg::*;
#(
   parameter int RADIX = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       step_en,
   input  logic       dir,
   input  logic       load,
   input  logic [3:0] load_d,
   input  logic       clr,
   output logic [3:0] q,
   output logic       co
);

   localparam digit_t MAX = digit_t'(RADIX - 1);

   logic [3:0] q_d;
   logic [3:0] q_q;

   // Next digit value: clear beats load beats step; out-of-range loads clamp to the top value.
   always_comb begin
      q_d = q_q;
      if (clr) begin
         q_d = 4'd0;
      end else if (load) begin
         q_d = (load_d > MAX) ? MAX : load_d;
      end else if (step_en) begin
         if (dir) begin
            q_d = (q_q == 4'd0) ? MAX : (q_q - 4'd1);
         end else begin
            q_d = (q_q == MAX) ? 4'd0 : (q_q + 4'd1);
         end
      end else begin
         q_d = q_q;
      end
   end

   // Digit register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_q <= 4'd0;
      end else begin
         q_q <= q_d;
      end
   end

   // Carry (up) or borrow (down) ripples combinationally into the next digit.
   assign co = step_en & (dir ? (q_q == 4'd0) : (q_q == MAX));
   assign q  = q_q;

endmodule

// File: rtl/stopwatch_timer.sv
// Prescaled mixed-radix BCD up/down counter with load, done flag and lap hold.
module stopwatch_timer
   import stopwatch_pkg::*;
#(
   parameter int          TICK_DIV   = 10_000_000,
   parameter int          NUM_DIGITS = 4,
   parameter logic [31:0] RADIX      = DEFAULT_RADIX,
   parameter int          WRAP       = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    run,
   input  logic                    clear,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] load_val,
   input  logic                    dir,
   input  logic                    lap,
   output logic [4*NUM_DIGITS-1:0] digits,
   output logic [4*NUM_DIGITS-1:0] disp,
   output logic                    lap_active,
   output logic                    tick,
   output logic                    done
);

   localparam int          W         = 4 * NUM_DIGITS;
   localparam int          PW        = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
   localparam logic        SATURATE  = (WRAP == 0);

   logic [PW-1:0] presc_d, presc_q;
   logic          done_d, done_q;
   logic [W-1:0]  lap_d, lap_q;
   logic          lap_active_d, lap_active_q;
   logic [W-1:0]  digits_s;
   logic          tick_s, all_max_s, all_zero_s, one_s, hold_s, step0_s;

   assign tick_s     = run & (presc_q == PRESC_MAX) & ~clear & ~load & ~reset;
   assign all_zero_s = (digits_s == {W{1'b0}});
   assign one_s      = (digits_s == W'(1));
   // No step at all when saturated at max (up) or already at zero (down).
   assign hold_s     = dir ? all_zero_s : (all_max_s & SATURATE);
   assign step0_s    = tick_s & ~hold_s;

   // Detect every digit sitting at its radix-1.
   always_comb begin
      all_max_s = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (digits_s[i*4 +: 4] != (radix_of(RADIX, i) - 4'd1)) begin
            all_max_s = 1'b0;
         end else begin
            all_max_s = all_max_s;
         end
      end
   end

   // Digit chain: digit 0 steps on tick, each later digit steps on its neighbour's carry/borrow.
   for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_dig
      logic step_s;
      logic co_s;
      if (gi == 0) begin : g_first
         assign step_s = step0_s;
      end else begin : g_next
         assign step_s = g_dig[gi-1].co_s;
      end
      bcd_digit_cell #(
         .RADIX (int'(radix_of(RADIX, gi)))
      ) u_cell (
         .clk     (clk),
         .reset   (reset),
         .step_en (step_s),
         .dir     (dir),
         .load    (load),
         .load_d  (load_val[gi*4 +: 4]),
         .clr     (clear),
         .q       (digits_s[gi*4 +: 4]),
         .co      (co_s)
      );
   end

   // Prescaler: restarts on clear/load, wraps at TICK_DIV-1, freezes while stopped.
   always_comb begin
      presc_d = presc_q;
      if (clear || load) begin
         presc_d = {PW{1'b0}};
      end else if (run) begin
         presc_d = (presc_q == PRESC_MAX) ? {PW{1'b0}} : (presc_q + PW'(1));
      end else begin
         presc_d = presc_q;
      end
   end

   // Sticky done: set by reaching zero counting down or by a saturated up step.
   always_comb begin
      done_d = done_q;
      if (clear || load) begin
         done_d = 1'b0;
      end else if (tick_s) begin
         if (dir && (all_zero_s || one_s)) begin
            done_d = 1'b1;
         end else if (!dir && all_max_s && SATURATE) begin
            done_d = 1'b1;
         end else begin
            done_d = done_q;
         end
      end else begin
         done_d = done_q;
      end
   end

   // Lap hold toggles on each pulse, capturing the pre-update count when engaging.
   always_comb begin
      lap_d        = lap_q;
      lap_active_d = lap_active_q;
      if (clear) begin
         lap_active_d = 1'b0;
      end else if (lap) begin
         if (lap_active_q) begin
            lap_active_d = 1'b0;
         end else begin
            lap_active_d = 1'b1;
            lap_d        = digits_s;
         end
      end else begin
         lap_active_d = lap_active_q;
      end
   end

   // Control state registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc_q      <= {PW{1'b0}};
         done_q       <= 1'b0;
         lap_q        <= {W{1'b0}};
         lap_active_q <= 1'b0;
      end else begin
         presc_q      <= presc_d;
         done_q       <= done_d;
         lap_q        <= lap_d;
         lap_active_q <= lap_active_d;
      end
   end

   assign digits     = digits_s;
   assign disp       = lap_active_q ? lap_q : digits_s;
   assign lap_active = lap_active_q;
   assign tick       = tick_s;
   assign done       = done_q;

endmodule

// File: doc/stopwatch_timer.md
Name: stopwatch_timer

Overview:
Parametrised successor to the two-button stopwatch counter. A prescaler divides clk into ticks, and a chain of N BCD digits with per-digit radix counts up or down on each tick. Adds load, countdown with done flag, wrap/saturate selection and a lap (split) hold on the display path. Feeds the seven-segment display mux directly.

Parameters:
TICK_DIV, 10_000_000, clk cycles per count tick (>=2)
NUM_DIGITS, 4, number of BCD digits (1..8)
RADIX, 32'h0000_A6AA, packed 4-bit radix per digit, digit 0 in LSBs; default gives d0=10, d1=10, d2=6, d3=10 (each 2..10)
WRAP, 1, 1 = up-count wraps max->0; 0 = up-count saturates at max and sets done

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
run  in  1  level; 1 = prescaler advances (start/stop)
clear  in  1  synchronous one-cycle pulse; zero everything
load  in  1  synchronous one-cycle pulse; load load_val
load_val  in  4*NUM_DIGITS  packed BCD preset
dir  in  1  0 = count up, 1 = count down
lap  in  1  one-cycle pulse; toggles lap hold
digits  out  4*NUM_DIGITS  live count, digit 0 in LSBs
disp  out  4*NUM_DIGITS  lap_active ? lap register : digits
lap_active  out  1  lap hold engaged
tick  out  1  one-cycle strobe on each count step
done  out  1  sticky terminal flag

Behaviour:
- Reset (async): prescaler=0, digits=0, lap register=0, lap_active=0, done=0. tick=0 while reset is high.
- Prescaler: counts 0..TICK_DIV-1 while run=1; holds its value while run=0, so sub-tick phase is preserved across a pause.
- tick = run & (prescaler==TICK_DIV-1) & ~clear & ~load, combinational. On that edge the prescaler returns to 0 and digits step, so digits change on the edge that ends the tick-high cycle.
- Priority each cycle: clear > load > tick.
- clear: prescaler=0, digits=0, done=0, lap_active=0. Takes effect regardless of run.
- load: digits=load_val, prescaler=0, done=0. Any digit >= its radix is loaded as radix-1. lap state is unchanged.
- Up step: digit 0 increments. A digit at radix-1 wraps to 0 and carries into the next digit.
  - All digits at max with WRAP=1: wrap to all zeros; done unaffected.
  - All digits at max with WRAP=0: count holds and done=1.
- Down step: digit 0 decrements. A digit at 0 borrows and becomes radix-1.
  - A step that reaches all zeros sets done=1 on the same edge.
  - Once at all zeros in down mode, further ticks leave the count at zero (no underflow wrap). tick still pulses.
- done is sticky until clear, load or reset. dir changes apply from the next tick; a dir change alone does not clear done.
- Lap:
  - lap pulse with lap_active=0: lap register captures the pre-update digits value of that cycle and lap_active=1.
  - lap pulse with lap_active=1: lap_active=0.
  - Counting continues underneath. lap coinciding with clear: clear wins, and lap_active ends at 0.
- disp is a combinational mux, with no added latency.
- Width rules: all digit arithmetic is 4-bit per digit. Carry and borrow chains are combinational across all digits within one cycle.

Decomposition:
- Package stopwatch_pkg: digit_t (logic [3:0]), DEFAULT_RADIX constant, and function radix_of(RADIX, i) returning the 4-bit radix of digit i.
- One sub-module, bcd_digit_cell, instantiated NUM_DIGITS times in a generate loop.
  - Parameter: RADIX.
  - Inputs: step_en, dir, load, load_d, clr.
  - Outputs: q, and carry/borrow out (asserted when the digit is at max for up or 0 for down, and step_en=1).
- The top level owns the prescaler, the done/saturate logic, the lap register and the disp mux.

Test Plan:
1. Prescale and pause (TICK_DIV=4, defaults): reset, run=1 -> tick every 4th cycle, digits 0000->0001->0002. At prescaler=2, drop run for 10 cycles, then re-raise -> next tick exactly 2 run cycles later, digits=0003.
2. Mixed-radix carry: load 0599 (hex-packed BCD), dir=0 -> next tick digits=1000. Load 9599 with WRAP=1 -> 0000, done=0. Rebuild with WRAP=0 -> stays 9599, done=1 and held across 3 more ticks.
3. Countdown: load 0002, dir=1 -> 0001, then 0000 with done=1 on that edge -> 5 further ticks leave 0000, done=1 -> load 0010 clears done -> next tick 0009.
4. Lap: count to 0007, pulse lap -> disp=0007, lap_active=1, while digits reach 0012. Pulse lap again -> disp tracks digits. Pulse lap and clear together -> digits=0000, lap_active=0.
5. Priority: assert clear and load together on a tick cycle -> digits=0000, tick=0. Assert load alone on a tick cycle -> digits=load_val, prescaler restarts, next tick 4 cycles later.
6. Async reset mid-count (digits=0345, lap_active=1) between clock edges -> all outputs 0 immediately, without waiting for a clk edge. After reset release, counting resumes from 0000.
